// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM state
// encodings and default busy-cycle counts.
// Optional accumulate ops (MADD/MADDU/MSUB/MSUBU) are enabled by MDU_MADD_EN.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MADD  = 4'd7;
    localparam logic [3:0] MDU_MADDU = 4'd8;
    localparam logic [3:0] MDU_MSUB  = 4'd9;
    localparam logic [3:0] MDU_MSUBU = 4'd10;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam int MDU_MULT_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF  = 10;

endpackage

// File: rtl/mdu_timer.sv
// Loadable 5-bit down-counter for the MDU busy period. done_o flags the
// terminal count (counter == 1), i.e. the edge on which the count reaches 0.
module mdu_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [4:0] load_val_i,
    output logic       done_o
);

    logic [4:0] cnt_q;
    logic [4:0] cnt_d;

    // Next count: load wins, otherwise count down and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != 5'd0) begin
            cnt_d = cnt_q - 5'd1;
        end
    end

    // Counter register, cleared asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= 5'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 5'd1);

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller with architectural HI/LO.
// The result is computed at issue and held as pending until the busy period
// expires, then committed. Define MDU_MADD_EN to enable MADD/MADDU/MSUB/MSUBU.
//
// state | meaning
// IDLE  | no operation in flight; accepts mult/div/mthi/mtlo
// RUN   | timer counting down; pending result committed at terminal count
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        id_md,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    logic        state_q, state_d;
    logic [63:0] pend_q, pend_d;
    logic        skip_q, skip_d;
    logic [31:0] hi_q, lo_q;

    logic        is_mul, is_div, issue, start_mul, start_div, done;
    logic [63:0] prod_s, prod_u, mul_res, div_res;
    logic [31:0] dvs, quo, rem;
    logic        div_ovf;

    // Decode which ops are multiply-class and divide-class.
    always_comb begin
        is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (op == MDU_MADD) || (op == MDU_MADDU)
                        || (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
        is_div = (op == MDU_DIV) || (op == MDU_DIVU);
    end

    assign issue     = (state_q == ST_IDLE) && start;
    assign start_mul = issue && is_mul;
    assign start_div = issue && is_div;

    // Products: sign-extended operands give the exact 64-bit signed product.
    assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign prod_u = {32'd0, A} * {32'd0, B};

    // Multiply-class result, including the optional accumulate against {HI,LO}.
    always_comb begin
        mul_res = (op == MDU_MULTU) ? prod_u : prod_s;
`ifdef MDU_MADD_EN
        case (op)
            MDU_MADD:  mul_res = {hi_q, lo_q} + prod_s;
            MDU_MADDU: mul_res = {hi_q, lo_q} + prod_u;
            MDU_MSUB:  mul_res = {hi_q, lo_q} - prod_s;
            MDU_MSUBU: mul_res = {hi_q, lo_q} - prod_u;
            default:   ;
        endcase
`endif
    end

    // Divide result as {remainder, quotient}; zero divisor is masked to keep
    // the divider defined, the result is discarded via skip_q anyway.
    // The one signed overflow case is forced to its architectural value.
    always_comb begin
        dvs     = (B == 32'd0) ? 32'd1 : B;
        div_ovf = (op == MDU_DIV) && (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        if (op == MDU_DIVU) begin
            quo = A / dvs;
            rem = A % dvs;
        end else if (div_ovf) begin
            quo = 32'h8000_0000;
            rem = 32'd0;
        end else begin
            quo = $signed(A) / $signed(dvs);
            rem = $signed(A) % $signed(dvs);
        end
        div_res = {rem, quo};
    end

    mdu_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (start_mul || start_div),
        .load_val_i (start_mul ? 5'(MULT_CYCLES) : 5'(DIV_CYCLES)),
        .done_o     (done)
    );

    // FSM next state plus pending result capture at the issue edge.
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        skip_d  = skip_q;
        case (state_q)
            ST_IDLE: begin
                if (start_mul) begin
                    state_d = ST_RUN;
                    pend_d  = mul_res;
                    skip_d  = 1'b0;
                end else if (start_div) begin
                    state_d = ST_RUN;
                    pend_d  = div_res;
                    skip_d  = (B == 32'd0);
                end
            end
            default: begin
                if (done) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // State and pending-result registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            pend_q  <= 64'd0;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            skip_q  <= skip_d;
        end
    end

    // HI/LO: commit at terminal count, or direct writes from MTHI/MTLO.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hi_q <= 32'd0;
            lo_q <= 32'd0;
        end else if ((state_q == ST_RUN) && done) begin
            if (!skip_q) begin
                hi_q <= pend_q[63:32];
                lo_q <= pend_q[31:0];
            end
        end else if (issue && (op == MDU_MTHI)) begin
            hi_q <= A;
        end else if (issue && (op == MDU_MTLO)) begin
            lo_q <= A;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign stall_req = id_md && (busy || start);
    assign HI        = hi_q;
    assign LO        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed testbench for mdu_ctrl with hand-computed expected values.
module tb_mdu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] A, B;
    logic        id_md;
    logic        busy, stall_req;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;

    mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .A         (A),
        .B         (B),
        .id_md     (id_md),
        .busy      (busy),
        .stall_req (stall_req),
        .HI        (HI),
        .LO        (LO)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        #1;
    endtask

    // Drop start after the issue edge and scramble the operands.
    task automatic release_cmd();
        start = 1'b0;
        op    = 4'd0;
        A     = $urandom;
        B     = $urandom;
        #1;
    endtask

    // Check n busy cycles with HI/LO held at their pre-issue values.
    task automatic busy_cycles(input int n, input logic exp_stall,
                               input logic [31:0] hi0, input logic [31:0] lo0);
        for (int i = 0; i < n; i++) begin
            check("busy_high", busy, 1'b1);
            check("stall_busy", stall_req, exp_stall);
            check("hi_hold", HI, hi0);
            check("lo_hold", LO, lo0);
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        start = 1'b0;
        op    = 4'd0;
        A     = 32'd0;
        B     = 32'd0;
        id_md = 1'b0;
        #3;
        check("rst_busy", busy, 1'b0);
        check("rst_hi", HI, 32'd0);
        check("rst_lo", LO, 32'd0);
        #9 reset = 1'b1;
        tick();

        // Signed multiply with stall request raised from the issue cycle on.
        id_md = 1'b1;
        check("stall_idle", stall_req, 1'b0);
        issue(4'd1, 32'hFFFF_FFFD, 32'd5);
        check("stall_issue", stall_req, 1'b1);
        tick();
        release_cmd();
        busy_cycles(5, 1'b1, 32'd0, 32'd0);
        check("mult_busy_fall", busy, 1'b0);
        check("mult_stall_fall", stall_req, 1'b0);
        check("mult_hi", HI, 32'hFFFF_FFFF);
        check("mult_lo", LO, 32'hFFFF_FFF1);

        // Unsigned divide with id_md low: no stall at any point.
        id_md = 1'b0;
        issue(4'd4, 32'd100, 32'd7);
        check("divu_stall_issue", stall_req, 1'b0);
        tick();
        release_cmd();
        busy_cycles(10, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        check("divu_busy_fall", busy, 1'b0);
        check("divu_lo", LO, 32'd14);
        check("divu_hi", HI, 32'd2);

        // Signed divide truncates toward zero; remainder follows dividend.
        issue(4'd3, 32'hFFFF_FFF9, 32'd2);
        tick();
        release_cmd();
        busy_cycles(10, 1'b0, 32'd2, 32'd14);
        check("div_lo", LO, 32'hFFFF_FFFD);
        check("div_hi", HI, 32'hFFFF_FFFF);

        // MTHI then divide by zero: full busy period, HI/LO retained.
        issue(4'd5, 32'h0000_1234, 32'd0);
        tick();
        release_cmd();
        check("mthi_busy", busy, 1'b0);
        check("mthi_hi", HI, 32'h0000_1234);
        check("mthi_lo", LO, 32'hFFFF_FFFD);
        issue(4'd3, 32'd55, 32'd0);
        tick();
        release_cmd();
        busy_cycles(10, 1'b0, 32'h0000_1234, 32'hFFFF_FFFD);
        check("div0_busy_fall", busy, 1'b0);
        check("div0_hi", HI, 32'h0000_1234);
        check("div0_lo", LO, 32'hFFFF_FFFD);

        // Signed overflow corner.
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
        tick();
        release_cmd();
        busy_cycles(10, 1'b0, 32'h0000_1234, 32'hFFFF_FFFD);
        check("ovf_lo", LO, 32'h8000_0000);
        check("ovf_hi", HI, 32'd0);

        // NONE and an undefined op: no effect.
        issue(4'd0, 32'h1111_1111, 32'h2222_2222);
        tick();
        check("none_busy", busy, 1'b0);
        issue(4'd13, 32'h3333_3333, 32'h4444_4444);
        tick();
        release_cmd();
        check("undef_busy", busy, 1'b0);
        check("undef_hi", HI, 32'd0);
        check("undef_lo", LO, 32'h8000_0000);

`ifdef MDU_MADD_EN
        issue(4'd5, 32'd0, 32'd0);
        tick();
        issue(4'd6, 32'd10, 32'd0);
        tick();
        issue(4'd7, 32'd3, 32'd4);
        tick();
        release_cmd();
        busy_cycles(5, 1'b0, 32'd0, 32'd10);
        check("madd_busy_fall", busy, 1'b0);
        check("madd_hi", HI, 32'd0);
        check("madd_lo", LO, 32'd22);
`else
        issue(4'd7, 32'd3, 32'd4);
        tick();
        release_cmd();
        check("madd_off_busy", busy, 1'b0);
        tick();
        check("madd_off_busy2", busy, 1'b0);
        check("madd_off_hi", HI, 32'd0);
        check("madd_off_lo", LO, 32'h8000_0000);
`endif

        // Asynchronous reset in the middle of a divide.
        issue(4'd4, 32'd1000, 32'd3);
        tick();
        release_cmd();
        tick();
        tick();
        tick();
        check("pre_rst_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_hi", HI, 32'd0);
        check("async_rst_lo", LO, 32'd0);
        #1 reset = 1'b1;
        tick();
        issue(4'd6, 32'd7, 32'd0);
        tick();
        release_cmd();
        check("mtlo_after_rst_lo", LO, 32'd7);
        check("mtlo_after_rst_busy", busy, 1'b0);
        tick();
        check("mtlo_after_rst_hi", HI, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
